// File: rtl/tx_arb_pkg.sv
// Shared types and word packing for the TX FIFO write arbiter.
package tx_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    PAYLOAD,
    TRAILER,
    DRAIN
  } state_t;

  localparam logic [7:0] HDR_MARK = 8'hBC;
  localparam logic [7:0] TRL_MARK = 8'hDC;

  function automatic logic [31:0] pack_hdr(
    input logic [3:0]  g,
    input logic [15:0] fc
  );
    return {HDR_MARK, g, 4'h0, fc};
  endfunction

  function automatic logic [31:0] pack_trl(
    input logic [3:0]  g,
    input logic        tr,
    input logic [15:0] wc
  );
    return {TRL_MARK, g, tr, 3'b000, wc};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first set request at or above the pointer, with wrap.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0] i_req,
  input  logic [3:0]   i_ptr,
  output logic [3:0]   o_idx,
  output logic         o_any
);

  logic [31:0] w_req;
  logic [4:0]  w_j;

  assign w_req = 32'(i_req);

  always_comb begin
    o_idx = '0;
    o_any = 1'b0;
    w_j   = '0;
    for (int i = 0; i < N; i++) begin
      w_j = 5'(i) + {1'b0, i_ptr};
      if (w_j >= 5'(N)) w_j = w_j - 5'(N);
      if (!o_any && w_req[w_j]) begin
        o_any = 1'b1;
        o_idx = w_j[3:0];
      end
    end
  end

endmodule

// File: rtl/tx_fifo_write_arbiter.sv
// Shares the TX FIFO between packet sources; frames each packet
// with header/trailer words and truncates over-long packets.
module tx_fifo_write_arbiter
  import tx_arb_pkg::*;
#(
  parameter int N_REQ         = 4,
  parameter int MAX_PKT_WORDS = 16
) (
  input  logic                clk40MHz_i,
  input  logic                rst_n_i,
  input  logic                enable_i,
  input  logic [N_REQ-1:0]    req_valid_i,
  input  logic [N_REQ*32-1:0] req_data_i,
  input  logic [N_REQ-1:0]    req_last_i,
  output logic [N_REQ-1:0]    req_ready_o,
  input  logic                tx_fifo_full_i,
  output logic [31:0]         tx_fifo_wdata_o,
  output logic                tx_fifo_wr_n_o,
  output logic [3:0]          grant_o,
  output logic                busy_o,
  output logic [15:0]         frame_cnt_o
);

  localparam logic [15:0] MAX_W    = 16'(MAX_PKT_WORDS);
  localparam logic [3:0]  LAST_IDX = 4'(N_REQ - 1);

  state_t      r_state;
  logic [3:0]  r_grant;
  logic [3:0]  r_rr_ptr;
  logic [15:0] r_frame_cnt;
  logic [15:0] r_word_cnt;
  logic        r_trunc;

  logic        w_vld;
  logic        w_last;
  logic [31:0] w_data;
  logic        w_emit;
  logic        w_wr;
  logic        w_rdy;
  logic [31:0] w_wdata;
  logic [3:0]  w_idx;
  logic        w_any;

  rr_arbiter #(.N(N_REQ)) u_rr (
    .i_req (req_valid_i),
    .i_ptr (r_rr_ptr),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  assign w_vld  = 1'(req_valid_i >> r_grant);
  assign w_last = 1'(req_last_i >> r_grant);
  assign w_data = 32'(req_data_i >> {r_grant, 5'd0});

  always_comb begin
    w_emit  = 1'b0;
    w_wdata = '0;
    w_rdy   = 1'b0;
    unique case (r_state)
      HEADER: begin
        w_emit  = 1'b1;
        w_wdata = pack_hdr(r_grant, r_frame_cnt);
      end
      PAYLOAD: begin
        w_emit  = w_vld;
        w_wdata = w_data;
        w_rdy   = !tx_fifo_full_i;
      end
      TRAILER: begin
        w_emit  = 1'b1;
        w_wdata = pack_trl(r_grant, r_trunc, r_word_cnt);
      end
      DRAIN:   w_rdy = 1'b1;
      default: ;
    endcase
    // Outputs go quiet the moment reset is asserted.
    if (!rst_n_i) begin
      w_emit  = 1'b0;
      w_wdata = '0;
      w_rdy   = 1'b0;
    end
  end

  assign w_wr            = w_emit && !tx_fifo_full_i;
  assign tx_fifo_wr_n_o  = !w_wr;
  assign tx_fifo_wdata_o = w_wdata;
  assign req_ready_o     = w_rdy ? (N_REQ'(1) << r_grant) : '0;
  assign grant_o         = r_grant;
  assign busy_o          = rst_n_i && (r_state != IDLE);
  assign frame_cnt_o     = r_frame_cnt;

  always_ff @(posedge clk40MHz_i) begin
    if (!rst_n_i) begin
      r_state     <= IDLE;
      r_grant     <= '0;
      r_rr_ptr    <= '0;
      r_frame_cnt <= '0;
      r_word_cnt  <= '0;
      r_trunc     <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: if (enable_i && w_any) begin
          r_grant  <= w_idx;
          r_rr_ptr <= (w_idx == LAST_IDX) ? 4'd0 : w_idx + 4'd1;
          r_state  <= HEADER;
        end
        HEADER: if (w_wr) begin
          r_frame_cnt <= r_frame_cnt + 16'd1;
          r_word_cnt  <= '0;
          r_state     <= PAYLOAD;
        end
        PAYLOAD: if (w_wr) begin
          r_word_cnt <= r_word_cnt + 16'd1;
          if (w_last) begin
            r_trunc <= 1'b0;
            r_state <= TRAILER;
          end else if (r_word_cnt + 16'd1 == MAX_W) begin
            r_trunc <= 1'b1;
            r_state <= TRAILER;
          end
        end
        TRAILER: if (w_wr) begin
          r_state <= r_trunc ? DRAIN : IDLE;
        end
        DRAIN: if (w_vld && w_last) begin
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
